canny_hysteresis: RTL and testbench
===================================

CANNY_HYSTERESIS -- requirements
Module: canny_hysteresis

Interface
REQ-001 Parameter MAX_WIDTH, default 2048, maximum pixels per line held in each line buffer.
REQ-002 Parameter COL_W, default 11, column-counter width; SHALL satisfy 2^COL_W >= MAX_WIDTH.
REQ-003 s_axis_aclk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 s_axis_aresetn  in  1  reset, asynchronous assert, active-low.
REQ-005 enable  in  1  1 = hysteresis tracking; 0 = strong-only bypass.
REQ-006 s_axis_tvalid  in  1  input beat qualifier; there is no tready and no backpressure.
REQ-007 s_axis_tuser  in  1  start of frame; marks pixel (0,0).
REQ-008 s_axis_tlast  in  1  end of line; marks the last pixel of a row.
REQ-009 s_axis_tdata  in  2  edge class: 0 = none, 1 = weak, 2 = strong, 3 = treated as none.
REQ-010 m_axis_tvalid / m_axis_tuser / m_axis_tlast  out  1 each  input controls delayed by 3 clocks.
REQ-011 m_axis_tdata  out  8  edge map pixel, 8'd255 = edge, 8'd0 = no edge.
REQ-012 overflow_err  out  1  sticky; a line exceeded MAX_WIDTH.

Function
REQ-013 Each output beat SHALL appear exactly 3 clocks after its input beat, independent of tvalid gaps; control bits are delayed unchanged.
REQ-014 The column counter SHALL advance on each valid beat, SHALL clear after a tlast beat, and SHALL clear on a tuser beat (tuser beat = column 0).
REQ-015 The row counter SHALL clear on a tuser beat, SHALL increment after each tlast beat, and SHALL saturate at 3.
REQ-016 Two line buffers of MAX_WIDTH x 2 bit SHALL hold rows r-1 and r-2, addressed by column; they SHALL be written only on valid beats.
REQ-017 A 3x3 flag window SHALL shift one column per valid beat only; it SHALL hold while tvalid is low.
REQ-018 The output at input position (r,c) SHALL be the decision for centre pixel (r-1,c-1).
REQ-019 Any window cell at row < 0 or column < 0 SHALL be read as flag 0; masking uses the counters, not buffer contents.
REQ-020 Output pixels with r = 0 or c = 0 SHALL be 8'd0; the final row and column of each frame are not emitted.
REQ-021 Decision with enable=1: centre strong -> 255; centre weak and any of 8 neighbours strong -> 255; otherwise -> 0. This is single pass; there is no iterative propagation.
REQ-022 Decision with enable=0: centre strong -> 255, else 0; latency SHALL remain 3.
REQ-023 m_axis_tdata SHALL be 0 on every clock where m_axis_tvalid = 0.
REQ-024 Column index >= MAX_WIDTH: the beat SHALL output 0, buffers SHALL NOT be written, and overflow_err SHALL set; it SHALL clear only on reset.
REQ-025 tuser and tlast on the same beat (width-1 line) SHALL be legal; the row counter SHALL advance and the column counter SHALL clear.

Reset
REQ-026 While s_axis_aresetn = 0, every output, counter, window cell and delay register SHALL be 0; line-buffer RAM SHALL NOT be reset.
REQ-027 After reset release, input beats SHALL be ignored (m_axis_tvalid = 0) until the first tuser beat; the same SHALL apply after a mid-frame reset.

Structure
REQ-028 Edge-class constants (NONE=0, WEAK=1, STRONG=2) and the EDGE_ON=255 value SHALL live in the shared canny package used by canny_NonMaxSupp.
REQ-029 The line buffers SHALL be one sub-module, canny_linebuf (simple dual-port, registered read, parameterised depth/width), instantiated twice.

Verification
REQ-030 Test 5x5 frame, all weak except strong at (2,2), enable=1: 255 exactly at output positions of centres (1..3,1..3), 0 elsewhere, including weak (0,*) and (*,0).
REQ-031 Test same frame, enable=0: a single 255 at the position of centre (2,2); every beat has latency 3.
REQ-032 Test 4x4 frame with tvalid deasserted every other clock: output values identical to the gapless run; each m_axis_tvalid lags its input by 3 clocks.
REQ-033 Test two back-to-back 4x4 frames, the first all strong and the second all weak: second frame output all 0, proving masking of stale buffer contents.
REQ-034 Test MAX_WIDTH=8 with a 10-pixel line: beats 8 and 9 output 0 and overflow_err = 1 and holds; next frame runs normally.
REQ-035 Test reset asserted mid-row, then beats without tuser, then a tuser frame: outputs 0 during reset, no m_axis_tvalid until the new tuser beat, then correct frame output.

Source files
------------

// File: rtl/canny_pkg.sv
// Shared Canny edge-class encodings and helpers.
// Used by the NMS and hysteresis stages.
package canny_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE   = 2'd0,
        EDGE_WEAK   = 2'd1,
        EDGE_STRONG = 2'd2
    } edge_class_e;

    localparam logic [7:0] EDGE_ON = 8'd255;

    // Returns {strong, weak}; the unused code 3 maps to no edge.
    function automatic logic [1:0] class_flags(input logic [1:0] cls);
        logic [1:0] flags;
        flags = 2'b00;
        if (cls == EDGE_STRONG) flags = 2'b10;
        else if (cls == EDGE_WEAK) flags = 2'b01;
        return flags;
    endfunction

endpackage

// File: rtl/canny_linebuf.sv
// Simple dual-port line buffer with a registered read port.
// Contents are never reset.
module canny_linebuf #(
    parameter int DEPTH = 2048,
    parameter int AW    = 11,
    parameter int DW    = 2
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/canny_hysteresis.sv
// Single-pass hysteresis over a 3x3 window of edge classes.
// Fixed three-clock latency from input beat to edge-map pixel.
module canny_hysteresis
    import canny_pkg::*;
#(
    parameter int MAX_WIDTH = 2048,
    parameter int COL_W     = 11
) (
    input  logic       s_axis_aclk,
    input  logic       s_axis_aresetn,
    input  logic       enable,
    input  logic       s_axis_tvalid,
    input  logic       s_axis_tuser,
    input  logic       s_axis_tlast,
    input  logic [1:0] s_axis_tdata,
    output logic       m_axis_tvalid,
    output logic       m_axis_tuser,
    output logic       m_axis_tlast,
    output logic [7:0] m_axis_tdata,
    output logic       overflow_err
);

    localparam logic [COL_W:0] COL_LIMIT = (COL_W + 1)'(MAX_WIDTH);
    localparam logic [COL_W:0] COL_ONE   = {{COL_W{1'b0}}, 1'b1};

    logic             in_frame;
    logic [COL_W:0]   col_cnt;
    logic [1:0]       row_cnt;
    logic             accept;
    logic [COL_W:0]   beat_col;
    logic [1:0]       beat_row;
    logic             beat_ovf;

    logic             v1, u1, l1, ovf1;
    logic [1:0]       pix1, row1;
    logic [COL_W:0]   col1;
    logic [1:0]       rd0, rd1;

    logic             v2, u2, l2, ovf2;
    logic [1:0]       row2;
    logic [COL_W:0]   col2;
    logic [1:0]       win [3][3];

    logic [2:0]       col_ok;
    logic             nb_strong;
    logic             pix_on;

    // Beats before the first start-of-frame are dropped entirely.
    assign accept   = s_axis_tvalid && (s_axis_tuser || in_frame);
    assign beat_col = s_axis_tuser ? '0 : col_cnt;
    assign beat_row = s_axis_tuser ? '0 : row_cnt;
    assign beat_ovf = beat_col >= COL_LIMIT;

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            in_frame     <= 1'b0;
            col_cnt      <= '0;
            row_cnt      <= '0;
            overflow_err <= 1'b0;
            v1           <= 1'b0;
            u1           <= 1'b0;
            l1           <= 1'b0;
            ovf1         <= 1'b0;
            pix1         <= '0;
            row1         <= '0;
            col1         <= '0;
        end else begin
            v1   <= accept;
            u1   <= accept && s_axis_tuser;
            l1   <= accept && s_axis_tlast;
            ovf1 <= beat_ovf;
            pix1 <= s_axis_tdata;
            row1 <= beat_row;
            col1 <= beat_col;
            if (accept) begin
                in_frame <= 1'b1;
                if (s_axis_tlast) begin
                    col_cnt <= '0;
                    row_cnt <= (beat_row == 2'd3) ? 2'd3 : beat_row + 2'd1;
                end else begin
                    row_cnt <= beat_row;
                    if (beat_col != '1) col_cnt <= beat_col + COL_ONE;
                end
                if (beat_ovf) overflow_err <= 1'b1;
            end
        end
    end

    // Writes trail the read by one clock so row r-1 can be copied down.
    canny_linebuf #(.DEPTH(MAX_WIDTH), .AW(COL_W), .DW(2)) u_line_r1 (
        .clk     (s_axis_aclk),
        .wr_en   (v1 && !ovf1),
        .wr_addr (col1[COL_W-1:0]),
        .wr_data (pix1),
        .rd_en   (accept),
        .rd_addr (beat_col[COL_W-1:0]),
        .rd_data (rd0)
    );

    canny_linebuf #(.DEPTH(MAX_WIDTH), .AW(COL_W), .DW(2)) u_line_r2 (
        .clk     (s_axis_aclk),
        .wr_en   (v1 && !ovf1),
        .wr_addr (col1[COL_W-1:0]),
        .wr_data (rd0),
        .rd_en   (accept),
        .rd_addr (beat_col[COL_W-1:0]),
        .rd_data (rd1)
    );

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            v2   <= 1'b0;
            u2   <= 1'b0;
            l2   <= 1'b0;
            ovf2 <= 1'b0;
            row2 <= '0;
            col2 <= '0;
            for (int unsigned r = 0; r < 3; r++)
                for (int unsigned c = 0; c < 3; c++)
                    win[r][c] <= '0;
        end else begin
            v2   <= v1;
            u2   <= u1;
            l2   <= l1;
            ovf2 <= ovf1;
            row2 <= row1;
            col2 <= col1;
            if (v1) begin
                for (int unsigned r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                // Rows above the frame top read as empty regardless of buffer contents.
                win[0][2] <= (row1 >= 2'd2) ? class_flags(rd1) : 2'b00;
                win[1][2] <= (row1 >= 2'd1) ? class_flags(rd0) : 2'b00;
                win[2][2] <= class_flags(pix1);
            end
        end
    end

    // Left window columns still hold the previous line until two beats in.
    assign col_ok = {1'b1, col2 != '0, col2 > COL_ONE};

    always_comb begin
        nb_strong = 1'b0;
        for (int unsigned r = 0; r < 3; r++)
            for (int unsigned c = 0; c < 3; c++)
                if (!(r == 1 && c == 1) && col_ok[c] && win[r][c][1])
                    nb_strong = 1'b1;
        pix_on = v2 && !ovf2 && (row2 != 2'd0) && (col2 != '0) &&
                 (win[1][1][1] || (enable && win[1][1][0] && nb_strong));
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
        end else begin
            m_axis_tvalid <= v2;
            m_axis_tuser  <= u2;
            m_axis_tlast  <= l2;
            m_axis_tdata  <= pix_on ? EDGE_ON : '0;
        end
    end

endmodule

// File: tb/tb_canny_hysteresis.sv
// Directed table-driven bench for canny_hysteresis (MAX_WIDTH=8 instance).
// Each table entry is one clock of input and its output three clocks later.
module tb_canny_hysteresis;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       s_tvalid, s_tuser, s_tlast;
    logic [1:0] s_tdata;
    logic       m_tvalid, m_tuser, m_tlast;
    logic [7:0] m_tdata;
    logic       ovf;

    always #5 clk = ~clk;

    canny_hysteresis #(.MAX_WIDTH(8), .COL_W(3)) dut (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (rst_n),
        .enable         (enable),
        .s_axis_tvalid  (s_tvalid),
        .s_axis_tuser   (s_tuser),
        .s_axis_tlast   (s_tlast),
        .s_axis_tdata   (s_tdata),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tuser   (m_tuser),
        .m_axis_tlast   (m_tlast),
        .m_axis_tdata   (m_tdata),
        .overflow_err   (ovf)
    );

    typedef struct {
        logic       v, u, l;
        logic [1:0] d;
        logic       ev, eu, el;
        logic [7:0] ed;
    } vec_t;

    vec_t        vec[$];
    logic [1:0]  img   [8][16];
    logic [15:0] emask [8];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic u, input logic l, input logic [1:0] d);
        s_tvalid = v;
        s_tuser  = u;
        s_tlast  = l;
        s_tdata  = d;
    endtask

    function automatic logic [15:0] all_outs();
        return {4'b0, m_tvalid, m_tuser, m_tlast, ovf, m_tdata};
    endfunction

    task automatic clear_img();
        for (int r = 0; r < 8; r++) begin
            emask[r] = '0;
            for (int c = 0; c < 16; c++) img[r][c] = 2'd0;
        end
    endtask

    task automatic fill_img(input int w, input int h, input logic [1:0] val);
        clear_img();
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) img[r][c] = val;
    endtask

    task automatic set_mixed();
        clear_img();
        img[1][1] = 2'd1;
        img[1][2] = 2'd2;
        img[2][1] = 2'd1;
        img[2][3] = 2'd1;
        emask[2]  = 16'h000C;
        emask[3]  = 16'h0004;
    endtask

    task automatic add_frame(input int w, input int h, input bit gaps);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                vec.push_back('{1'b1, (r == 0 && c == 0), (c == w - 1), img[r][c],
                                1'b1, (r == 0 && c == 0), (c == w - 1),
                                emask[r][c] ? 8'd255 : 8'd0});
                if (gaps) vec.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0});
            end
    endtask

    task automatic run_table(input string name, input bit drain);
        int n    = vec.size();
        int last = drain ? n + 2 : n;
        for (int i = 0; i < last; i++) begin
            if (i < n) drive(vec[i].v, vec[i].u, vec[i].l, vec[i].d);
            else       drive(1'b0, 1'b0, 1'b0, 2'd0);
            @(posedge clk);
            #1;
            if (i >= 2)
                check($sformatf("%s beat %0d", name, i - 2),
                      {5'b0, m_tvalid, m_tuser, m_tlast, m_tdata},
                      {5'b0, vec[i-2].ev, vec[i-2].eu, vec[i-2].el, vec[i-2].ed});
        end
        vec.delete();
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'd0);
        repeat (3) @(posedge clk);
        #1 check("reset idle", all_outs(), 16'h0);
        drive(1'b1, 1'b1, 1'b0, 2'd2);
        @(posedge clk);
        #1 check("reset with beat", all_outs(), 16'h0);
        drive(1'b0, 1'b0, 1'b0, 2'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("post reset idle", all_outs(), 16'h0);

        // 5x5 weak with a strong centre pixel
        fill_img(5, 5, 2'd1);
        img[2][2] = 2'd2;
        emask[2] = 16'h001C;
        emask[3] = 16'h001C;
        emask[4] = 16'h001C;
        add_frame(5, 5, 1'b0);
        run_table("hyst 5x5", 1'b1);

        enable = 1'b0;
        for (int r = 0; r < 8; r++) emask[r] = '0;
        emask[3] = 16'h0008;
        add_frame(5, 5, 1'b0);
        run_table("bypass 5x5", 1'b1);
        enable = 1'b1;

        set_mixed();
        add_frame(4, 4, 1'b0);
        run_table("mixed gapless", 1'b1);
        add_frame(4, 4, 1'b1);
        run_table("mixed gapped", 1'b1);

        clear_img();
        img[0][0] = 2'd3;
        img[0][2] = 2'd3;
        img[1][1] = 2'd1;
        add_frame(3, 3, 1'b0);
        run_table("code3 neighbour", 1'b1);

        fill_img(4, 4, 2'd2);
        emask[1] = 16'h000E;
        emask[2] = 16'h000E;
        emask[3] = 16'h000E;
        add_frame(4, 4, 1'b0);
        fill_img(4, 4, 2'd1);
        add_frame(4, 4, 1'b0);
        run_table("strong then weak", 1'b1);

        check("overflow clear", {15'b0, ovf}, 16'h0);
        fill_img(10, 2, 2'd2);
        emask[1] = 16'h00FE;
        add_frame(10, 2, 1'b0);
        run_table("overflow line", 1'b1);
        check("overflow set", {15'b0, ovf}, 16'h1);
        set_mixed();
        add_frame(4, 4, 1'b0);
        run_table("after overflow", 1'b1);
        check("overflow sticky", {15'b0, ovf}, 16'h1);

        // Mid-row reset, then orphan beats, then a clean frame
        fill_img(4, 4, 2'd2);
        add_frame(4, 4, 1'b0);
        while (vec.size() > 6) void'(vec.pop_back());
        run_table("pre reset", 1'b0);
        #2 rst_n = 1'b0;
        #1 check("mid reset", all_outs(), 16'h0);
        drive(1'b1, 1'b0, 1'b0, 2'd2);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1 check($sformatf("in reset %0d", k), all_outs(), 16'h0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++)
            vec.push_back('{1'b1, 1'b0, (k == 2), 2'd2, 1'b0, 1'b0, 1'b0, 8'd0});
        set_mixed();
        add_frame(4, 4, 1'b0);
        run_table("after reset", 1'b1);
        check("overflow after reset", {15'b0, ovf}, 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
